// File: rtl/trig_arb_pkg.sv
// Shared definitions for the trigger arbiter: FSM state encoding,
// trigger-source bit positions and the drop-counter width.
package trig_arb_pkg;

    // Arbiter states; BUSY is asserted in every state except ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DEAD     = 3'd4
    } state_t;

    // Bit positions of the trigger sources within TRIG_IN / SRC_ENAB / TRIG_TYPE.
    localparam int SRC_SB   = 0;   // single-bin
    localparam int SRC_TOT  = 1;   // time-over-threshold
    localparam int SRC_TOTD = 2;   // delayed time-over-threshold
    localparam int SRC_EXT  = 3;   // external trigger

    // Width of the dropped-trigger counter output.
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/trig_arb_cnt.sv
// Loadable down-counter used for both the coincidence window and the dead time.
// A load takes priority over a decrement; the count never wraps below zero.
// o_one flags the last running cycle so the owner can leave its state on the
// same edge that the count reaches zero.
module trig_arb_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_one
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Count register: synchronous clear, load, then saturating decrement.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == C_ONE);

endmodule

// File: rtl/trig_arbiter.sv
// Trigger arbiter: merges enabled one-cycle trigger pulses over a programmable
// coincidence window, emits a single global trigger with the contributing
// source mask, then holds off until readout acknowledge plus a dead time.
// Optional build macro TRIG_ARB_DROP_CNT_EN adds the saturating counter of
// cycles in which an enabled pulse arrived while busy; without it DROP_CNT is 0.
module trig_arbiter
    import trig_arb_pkg::*;
#(
    parameter int NSRC       = 4,
    parameter int WIN_WIDTH  = 4,
    parameter int DEAD_WIDTH = 16
) (
    input  logic                  CLK120,
    input  logic                  RESET_N,
    input  logic [NSRC-1:0]       TRIG_IN,
    input  logic [NSRC-1:0]       SRC_ENAB,
    input  logic [WIN_WIDTH-1:0]  WINDOW,
    input  logic [DEAD_WIDTH-1:0] DEAD_TIME,
    input  logic                  READOUT_ACK,
    output logic                  TRIG_OUT,
    output logic [NSRC-1:0]       TRIG_TYPE,
    output logic                  BUSY,
    output logic [DROP_CNT_W-1:0] DROP_CNT
);

    state_t          r_state;
    state_t          w_state_next;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] w_pend_next;
    logic            r_trig_out;
    logic [NSRC-1:0] r_trig_type;
    logic            r_busy;

    logic [NSRC-1:0] w_acc;
    logic            w_any;
    logic            w_issue;
    logic            w_win_load;
    logic            w_win_dec;
    logic            w_win_zero;
    logic            w_win_one;
    logic            w_dead_load;
    logic            w_dead_dec;
    logic            w_dead_zero;
    logic            w_dead_one;

    // A pulse counts only if its source is enabled in the same cycle.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_acc
        assign w_acc[gi] = TRIG_IN[gi] & SRC_ENAB[gi];
    end
    assign w_any = |w_acc;

    trig_arb_cnt #(.WIDTH(WIN_WIDTH)) u_win_cnt (
        .i_clk      (CLK120),
        .i_rst_n    (RESET_N),
        .i_load     (w_win_load),
        .i_load_val (WINDOW),
        .i_dec      (w_win_dec),
        .o_zero     (w_win_zero),
        .o_one      (w_win_one)
    );

    trig_arb_cnt #(.WIDTH(DEAD_WIDTH)) u_dead_cnt (
        .i_clk      (CLK120),
        .i_rst_n    (RESET_N),
        .i_load     (w_dead_load),
        .i_load_val (DEAD_TIME),
        .i_dec      (w_dead_dec),
        .o_zero     (w_dead_zero),
        .o_one      (w_dead_one)
    );

    // Next-state, pending-mask and counter-control decode.
    always_comb begin
        w_state_next = r_state;
        w_pend_next  = r_pend;
        w_issue      = 1'b0;
        w_win_load   = 1'b0;
        w_win_dec    = 1'b0;
        w_dead_load  = 1'b0;
        w_dead_dec   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_pend_next  = w_acc;
                    w_win_load   = 1'b1;
                    w_state_next = (WINDOW != '0) ? ST_COLLECT : ST_ISSUE;
                end
            end
            ST_COLLECT: begin
                // The cycle in which the count hits zero still collects pulses.
                w_pend_next = r_pend | w_acc;
                w_win_dec   = 1'b1;
                if (w_win_one || w_win_zero) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Any acknowledge seen here belongs to an earlier readout.
                w_issue      = 1'b1;
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (READOUT_ACK) begin
                    w_dead_load  = 1'b1;
                    w_state_next = (DEAD_TIME != '0) ? ST_DEAD : ST_IDLE;
                end
            end
            ST_DEAD: begin
                w_dead_dec = 1'b1;
                if (w_dead_one || w_dead_zero) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; TRIG_TYPE holds until the next issue.
    always_ff @(posedge CLK120) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_trig_out  <= 1'b0;
            r_trig_type <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pend     <= w_pend_next;
            r_trig_out <= w_issue;
            if (w_issue) begin
                r_trig_type <= r_pend;
            end
            r_busy <= (w_state_next != ST_IDLE);
        end
    end

    assign TRIG_OUT  = r_trig_out;
    assign TRIG_TYPE = r_trig_type;
    assign BUSY      = r_busy;

`ifdef TRIG_ARB_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_drop;

    // One drop per busy cycle (after the window) carrying any enabled pulse.
    assign w_drop = w_any && ((r_state == ST_ISSUE) ||
                              (r_state == ST_WAIT_ACK) ||
                              (r_state == ST_DEAD));

    // Saturating drop counter.
    always_ff @(posedge CLK120) begin
        if (!RESET_N) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign DROP_CNT = r_drop_cnt;
`else
    assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_trig_arbiter.sv
// Self-checking bench for trig_arbiter: directed vector table, hand-written
// reset/saturation sequences and randomized stimulus against a timestamp model.
module tb_trig_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  trig = 4'h0;
    logic [3:0]  enab = 4'hF;
    logic [3:0]  win = 4'h3;
    logic [15:0] dead = 16'd5;
    logic        ack = 1'b0;

    logic        trig_out;
    logic [3:0]  trig_type;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #4 clk = ~clk;

    trig_arbiter #(.NSRC(4), .WIN_WIDTH(4), .DEAD_WIDTH(16)) dut (
        .CLK120      (clk),
        .RESET_N     (rst_n),
        .TRIG_IN     (trig),
        .SRC_ENAB    (enab),
        .WINDOW      (win),
        .DEAD_TIME   (dead),
        .READOUT_ACK (ack),
        .TRIG_OUT    (trig_out),
        .TRIG_TYPE   (trig_type),
        .BUSY        (busy),
        .DROP_CNT    (drop_cnt)
    );

    // Reference model: tracks a trigger episode by edge timestamps
    // (first pulse, issue edge, ack edge, first free edge).
    int         n = 0;
    bit         m_active = 0;
    bit         m_acked = 0;
    int         m_issue = 0;
    int         m_free = 0;
    logic [3:0] m_pend = 0;
    logic [3:0] m_type = 0;
    int         m_drop = 0;
    bit         m_tout = 0;
    bit         m_busy = 0;

    function automatic int exp_drop(input int d);
`ifdef TRIG_ARB_DROP_CNT_EN
        return d;
`else
        return 0 * d;
`endif
    endfunction

    task automatic model_edge();
        logic [3:0] acc;
        acc = trig & enab;
        m_tout = 0;
        if (!rst_n) begin
            m_active = 0; m_acked = 0; m_pend = 0; m_type = 0; m_drop = 0; m_busy = 0;
        end else begin
            if (m_active && m_acked && n >= m_free) m_active = 0;
            if (!m_active) begin
                if (acc != 0) begin
                    m_active = 1; m_acked = 0; m_pend = acc;
                    m_issue = n + int'(win) + 1;
                end
            end else if (n < m_issue) begin
                m_pend |= acc;
            end else begin
                if (acc != 0 && m_drop < 65535) m_drop++;
                if (n == m_issue) begin
                    m_tout = 1; m_type = m_pend;
                end else if (!m_acked && ack) begin
                    m_acked = 1; m_free = n + int'(dead) + 1;
                end
            end
            m_busy = m_active && !(m_acked && (n + 1 >= m_free));
        end
        n++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, n - 1, act, exp);
        end
    endtask

    // One clock: model follows the same inputs; outputs sampled 1 time unit after the edge.
    task automatic step(input bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) begin
            check("model_trig_out", 32'(trig_out), 32'(m_tout));
            check("model_trig_type", 32'(trig_type), 32'(m_type));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_drop_cnt", 32'(drop_cnt), 32'(exp_drop(m_drop)));
        end
    endtask

    typedef struct {
        bit          rst_n;
        logic [3:0]  trig;
        logic [3:0]  enab;
        logic [3:0]  win;
        logic [15:0] dead;
        bit          ack;
        bit          e_tout;
        logic [3:0]  e_type;
        bit          e_busy;
        int          e_drop;
    } vec_t;

    function automatic vec_t mk(input bit r, input logic [3:0] t, input logic [3:0] e,
                                input logic [3:0] w, input logic [15:0] d, input bit a,
                                input bit eo, input logic [3:0] ety, input bit eb, input int ed);
        vec_t v;
        v.rst_n = r; v.trig = t; v.enab = e; v.win = w; v.dead = d; v.ack = a;
        v.e_tout = eo; v.e_type = ety; v.e_busy = eb; v.e_drop = ed;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        bit saw_trig;

        // Directed table: one record per clock edge.
        tbl.push_back(mk(0, 4'h0, 4'hF, 4'd3, 16'd5, 0,  0, 4'h0, 0, 0)); // reset
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd3, 16'd5, 0,  0, 4'h0, 0, 0)); // idle
        tbl.push_back(mk(1, 4'h1, 4'hF, 4'd3, 16'd5, 0,  0, 4'h0, 1, 0)); // first pulse, W=3
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd1, 16'd5, 0,  0, 4'h0, 1, 0)); // WINDOW change ignored
        tbl.push_back(mk(1, 4'h4, 4'hF, 4'd1, 16'd5, 0,  0, 4'h0, 1, 0)); // bit 2 joins
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd1, 16'd5, 0,  0, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd3, 16'd5, 0,  1, 4'h5, 1, 0)); // trigger out
        tbl.push_back(mk(1, 4'h2, 4'hF, 4'd3, 16'd5, 0,  0, 4'h5, 1, 1)); // drop 1
        tbl.push_back(mk(1, 4'hC, 4'hF, 4'd3, 16'd5, 0,  0, 4'h5, 1, 2)); // drop 2 (two bits)
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd3, 16'd5, 0,  0, 4'h5, 1, 2));
        tbl.push_back(mk(1, 4'h1, 4'hF, 4'd3, 16'd5, 0,  0, 4'h5, 1, 3)); // drop 3
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd3, 16'd5, 1,  0, 4'h5, 1, 3)); // ack, dead 5
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd0, 0,  0, 4'h5, 1, 3)); // DEAD_TIME change ignored
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd0, 0,  0, 4'h5, 1, 3));
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd0, 0,  0, 4'h5, 1, 3));
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd0, 0,  0, 4'h5, 1, 3));
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd0, 0,  0, 4'h5, 0, 3)); // busy falls
        tbl.push_back(mk(1, 4'h2, 4'hF, 4'd0, 16'd5, 0,  0, 4'h5, 1, 3)); // first idle cycle, W=0
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd5, 1,  1, 4'h2, 1, 3)); // ack in ISSUE ignored
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd5, 0,  0, 4'h2, 1, 3));
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd0, 16'd0, 1,  0, 4'h2, 0, 3)); // ack, dead 0
        tbl.push_back(mk(1, 4'h1, 4'hE, 4'd0, 16'd0, 0,  0, 4'h2, 0, 3)); // disabled source
        tbl.push_back(mk(1, 4'h1, 4'hE, 4'd0, 16'd0, 0,  0, 4'h2, 0, 3));
        tbl.push_back(mk(1, 4'h8, 4'hF, 4'd2, 16'd0, 0,  0, 4'h2, 1, 3)); // ext starts W=2
        tbl.push_back(mk(1, 4'h0, 4'h0, 4'd2, 16'd0, 0,  0, 4'h2, 1, 3)); // enables cleared
        tbl.push_back(mk(1, 4'h1, 4'h0, 4'd2, 16'd0, 0,  0, 4'h2, 1, 3)); // masked pulse
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd2, 16'd0, 0,  1, 4'h8, 1, 3)); // PEND kept
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd2, 16'd0, 1,  0, 4'h8, 0, 3));
        tbl.push_back(mk(1, 4'h0, 4'hF, 4'd2, 16'd0, 0,  0, 4'h8, 0, 3));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n; trig = tbl[i].trig; enab = tbl[i].enab;
            win = tbl[i].win; dead = tbl[i].dead; ack = tbl[i].ack;
            step(1);
            check($sformatf("vec%0d_trig_out", i), 32'(trig_out), 32'(tbl[i].e_tout));
            check($sformatf("vec%0d_trig_type", i), 32'(trig_type), 32'(tbl[i].e_type));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(exp_drop(tbl[i].e_drop)));
        end

        // Disabled source after reset: nothing happens, no drops.
        rst_n = 0; trig = 0; ack = 0; step(1);
        rst_n = 1; enab = 4'hE; trig = 4'h1;
        for (int i = 0; i < 3; i++) step(1);
        check("masked_busy", 32'(busy), 32'd0);
        check("masked_drop", 32'(drop_cnt), 32'd0);

        // Reset in the middle of a long window aborts without a trigger.
        enab = 4'hF; win = 4'd8; trig = 4'h1; step(1);
        trig = 4'h0;
        for (int i = 0; i < 3; i++) step(1);
        rst_n = 0; trig = 4'h2; step(1);
        check("rst_trig_out", 32'(trig_out), 32'd0);
        check("rst_trig_type", 32'(trig_type), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst_n = 1; trig = 4'h0;
        saw_trig = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (trig_out) saw_trig = 1;
        end
        check("rst_no_late_trig", 32'(saw_trig), 32'd0);

        // Saturation: hold in WAIT_ACK with a pulse every cycle.
        win = 4'd0; dead = 16'd0; trig = 4'h1; step(1);
        trig = 4'h0; step(1);
        trig = 4'hF;
        for (int i = 0; i < 65600; i++) step((i % 8192) == 0);
        check("drop_sat", 32'(drop_cnt), 32'(exp_drop(65535)));
        trig = 4'h0; ack = 1; step(1);
        ack = 0; step(1);
        check("after_sat_busy", 32'(busy), 32'd0);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            trig  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            enab  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            win   = 4'($urandom_range(0, 6));
            dead  = 16'($urandom_range(0, 12));
            ack   = ($urandom_range(0, 5) == 0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
